acc_drain: RTL and testbench
============================

# acc_drain

Readout stage directly downstream of the accumulator. On `start`, it reads a contiguous address range through the accumulator's read port and absorbs the fixed 2-cycle read latency. Each 64-bit word is reduced lane-wise mod 2^LOGQ and streamed out on a valid/ready interface. When `clear` is set, each drained address is optionally zeroed through the accumulator's write port in overwrite mode, leaving the RAM ready for the next accumulation phase.

## Interface
- `ADDR_WIDTH`, 9: accumulator address width.
- `DATA_WIDTH`, 64: word width; must be a multiple of `LANE_WIDTH`.
- `LANE_WIDTH`, 16: SIMD lane width, matching the accumulator's lanes.
- `LOGQ`, 15: output modulus exponent, 1..`LANE_WIDTH`.
- `RD_LATENCY`, 2: accumulator read latency, in cycles.
- `FIFO_DEPTH`, 4: output buffer depth; must be ≥ `RD_LATENCY`+1.
- `clk` in 1: the single clock.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: launches a drain; sampled only in IDLE.
- `base_addr` in ADDR_WIDTH: first address; latched at start.
- `length` in ADDR_WIDTH+1: word count, 0..2^ADDR_WIDTH; latched at start.
- `clear` in 1: zero each address after reading it; latched at start.
- `busy` out 1: high from the cycle after start until done.
- `done` out 1: one-cycle completion pulse.
- `rd_en` out 1: accumulator read enable.
- `rd_addr` out ADDR_WIDTH: accumulator read address.
- `rd_data` in DATA_WIDTH: accumulator read data.
- `wr_en` out 1: accumulator write enable.
- `wr_we` out 1: accumulator write strobe.
- `wr_addr` out ADDR_WIDTH: accumulator write address.
- `wr_wdata` out DATA_WIDTH: accumulator write data.
- `acc_mode` out 1: accumulator mode select; held at 0 (overwrite).
- `m_valid` out 1: output word valid.
- `m_ready` in 1: downstream ready.
- `m_data` out DATA_WIDTH: output word.
- `m_last` out 1: marks the final word of a drain.

## Operation
- FSM states: IDLE, RUN, FLUSH, DONE.
  - IDLE → RUN on `start` with `length` > 0.
  - IDLE → DONE on `start` with `length` = 0; no reads, no writes.
  - RUN → FLUSH once all `length` reads are issued.
  - FLUSH → DONE once the FIFO is empty, no reads are outstanding, and the last write is issued.
  - DONE → IDLE unconditionally; `done` is high in DONE.
- Read issue: in RUN, `rd_en` is asserted when `outstanding + fifo_count < FIFO_DEPTH`.
  - This credit rule makes FIFO overflow impossible.
  - `rd_addr` = (`base_addr` + issued count) mod 2^ADDR_WIDTH; the range wraps at the top of memory.
- Return tracking: a RD_LATENCY-deep valid shift register marks returning data. Each flagged `rd_data` is pushed into the FIFO unconditionally.
- Lane reduction: `m_data` lane k = `rd_data[k*16 +: 16]` & (2^LOGQ − 1). With LOGQ = LANE_WIDTH the data passes through unchanged. No carries cross lanes.
- Clear:
  - When `clear` is latched, a write with `wr_en`=`wr_we`=1 and `wr_wdata`=0 to address A is issued in the cycle A's data returns.
  - It is never issued in the read cycle itself, so no same-cycle read/write occurs on one address.
  - When `clear` is 0, `wr_en`/`wr_we` stay 0.
- `m_last` = 1 on the FIFO head that is the `length`-th word.
- `start` in any state other than IDLE is ignored.
- Reset, including mid-drain:
  - FSM returns to IDLE; FIFO, counters and pipeline are flushed.
  - In-flight returns are discarded and no further clear writes are issued.
- Reset values: all outputs 0.

## Timing
- `start` sampled at edge s.
  - RUN begins in cycle s+1; first `rd_en` in s+1.
  - First data returns in s+3 and is pushed at the end of s+3.
  - First `m_valid` in s+4.
- Read latency: `rd_en` high in cycle c means `rd_data` is valid in cycle c+RD_LATENCY.
- Sustained throughput is 1 word/cycle while `m_ready`=1.
- Stall: with `m_ready`=0, reads stop once credits are exhausted; at most FIFO_DEPTH words are held.
- Handshake: a transfer occurs when `m_valid` & `m_ready` at a posedge.
  - `m_data`/`m_last` stay stable while `m_valid`=1 and `m_ready`=0.
  - `m_valid` never drops without a transfer.
- `done` is high in the cycle after the final transfer; `busy` falls in the same cycle.
- Zero length: `done` is high in s+1.

## Structure
- Package `acc_pkg` holds:
  - `drain_state_e` (IDLE/RUN/FLUSH/DONE);
  - constants `LANE_WIDTH`=16 and `ACC_RD_LATENCY`=2;
  - function `lane_mask(data, logq)`.
- One sub-module, `drain_fifo`: a synchronous FIFO of DATA_WIDTH+1 bits (data + last) with `count` output, used as the output buffer.

## Test plan
- Preload addresses 0x10..0x13 with 0x0001_0002_0003_8004 + i; drain with base 0x10, length 4, clear=0, `m_ready`=1.
  - Expect 4 words in cycles s+4..s+7, top lane bit masked (lane0 = 0x0004 + i).
  - `m_last` on word 4; `done` at s+8.
- Same drain with clear=1.
  - Expect exactly 4 zero-writes to 0x10..0x13 with `acc_mode`=0.
  - A later read of 0x10 returns 0.
- Drain base 0x1FE, length 4.
  - Reads hit 0x1FE, 0x1FF, 0x000, 0x001 in order.
- Length 8 with `m_ready` toggling 1,0,0,1 repeating.
  - No more than 4 words buffered; no drops or duplicates.
  - Data is stable through stalls; order is preserved.
- Length 0: no `rd_en`/`wr_en`, `done` at s+1.
- `rst` asserted mid-drain of length 16 with clear=1.
  - All outputs 0 the next cycle; no further writes.
  - A new `start` afterwards completes normally.

Source files
------------

// File: rtl/acc_pkg.sv
// acc_pkg: shared types and helpers for the accumulator readout path.
//   drain_state_e  : drain FSM states (IDLE/RUN/FLUSH/DONE)
//   LANE_WIDTH     : SIMD lane width of the accumulator words
//   ACC_RD_LATENCY : accumulator read latency in cycles
//   lane_mask()    : reduce one lane mod 2^logq
package acc_pkg;

    localparam int LANE_WIDTH     = 16;
    localparam int ACC_RD_LATENCY = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2,
        DONE  = 2'd3
    } drain_state_e;

    // Keeps the low logq bits of a lane; logq >= LANE_WIDTH passes the lane through.
    function automatic logic [LANE_WIDTH-1:0] lane_mask(input logic [LANE_WIDTH-1:0] data,
                                                        input int logq);
        logic [LANE_WIDTH-1:0] m;
        for (int b = 0; b < LANE_WIDTH; b++) begin
            m[b] = (b < logq);
        end
        return data & m;
    endfunction

endpackage

// File: rtl/drain_fifo.sv
// drain_fifo: synchronous circular-buffer FIFO used as the drain output buffer.
//   clk, rst : clock, synchronous active-high reset (empties the FIFO)
//   push     : write wdata this cycle (caller guarantees not full)
//   wdata    : entry to store
//   pop      : retire the head entry this cycle (caller guarantees not empty)
//   rdata    : current head entry (meaningful only when count != 0)
//   count    : number of stored entries
module drain_fifo #(
    parameter int WIDTH = 65,
    parameter int DEPTH = 4,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic [CW-1:0]    count
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;

    function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= ptr_next(wr_ptr);
            if (pop)  rd_ptr <= ptr_next(rd_ptr);
            count <= count + CW'(push) - CW'(pop);
        end
    end

    // Storage needs no reset: entries are only observed through count.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= wdata;
    end

    assign rdata = mem[rd_ptr];

endmodule

// File: rtl/acc_drain.sv
// acc_drain: reads a contiguous address range out of the accumulator, reduces
// every lane mod 2^LOGQ and streams the words downstream; optionally zeroes
// each drained address through the accumulator write port.
//   start/base_addr/length/clear : drain command, latched in IDLE
//   busy, done                   : drain in progress / one-cycle completion
//   rd_en/rd_addr/rd_data        : accumulator read port (RD_LATENCY cycles)
//   wr_en/wr_we/wr_addr/wr_wdata : accumulator write port (zero writes)
//   acc_mode                     : accumulator mode, held at overwrite (0)
//   m_valid/m_ready/m_data/m_last: output stream
//   dbg_state                    : current FSM state
//
// Output handshake: a word transfers at a posedge where m_valid && m_ready;
// while m_valid is high and m_ready low, m_data/m_last hold and m_valid stays
// high until the transfer happens.
module acc_drain #(
    parameter int ADDR_WIDTH = 9,
    parameter int DATA_WIDTH = 64,
    parameter int LANE_WIDTH = 16,
    parameter int LOGQ       = 15,
    parameter int RD_LATENCY = 2,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [ADDR_WIDTH:0]   length,
    input  logic                  clear,
    output logic                  busy,
    output logic                  done,
    output logic                  rd_en,
    output logic [ADDR_WIDTH-1:0] rd_addr,
    input  logic [DATA_WIDTH-1:0] rd_data,
    output logic                  wr_en,
    output logic                  wr_we,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    output logic [DATA_WIDTH-1:0] wr_wdata,
    output logic                  acc_mode,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_last,
    output logic [1:0]            dbg_state
);

    import acc_pkg::*;

    localparam int LANES = DATA_WIDTH / LANE_WIDTH;
    localparam int CW    = $clog2(FIFO_DEPTH + 1);

    drain_state_e          state;
    logic [ADDR_WIDTH-1:0] base_q;
    logic [ADDR_WIDTH:0]   len_q;
    logic                  clear_q;
    logic [ADDR_WIDTH:0]   issue_cnt;
    logic [ADDR_WIDTH:0]   ret_cnt;

    // Return tracking: vld[RD_LATENCY-1] flags that rd_data is valid this
    // cycle, and apipe carries the matching address for the clear write.
    logic [RD_LATENCY-1:0] vld;
    logic [ADDR_WIDTH-1:0] apipe [RD_LATENCY];

    logic                  ret_valid;
    logic [ADDR_WIDTH-1:0] ret_addr;
    logic                  ret_last;
    int                    outstanding;
    logic                  credit_ok;

    logic [DATA_WIDTH-1:0] lane_data;
    logic [DATA_WIDTH:0]   fifo_head;
    logic [CW-1:0]         fifo_count;
    logic                  fifo_pop;

    assign ret_valid = vld[RD_LATENCY-1];
    assign ret_addr  = apipe[RD_LATENCY-1];
    assign ret_last  = (ret_cnt + 1'b1 == len_q);

    always_comb begin
        outstanding = 0;
        for (int i = 0; i < RD_LATENCY; i++) begin
            outstanding = outstanding + int'(vld[i]);
        end
    end

    // Every read in flight already owns a FIFO slot, so pushes never overflow.
    assign credit_ok = (outstanding + int'(fifo_count)) < FIFO_DEPTH;

    assign rd_en   = (state == RUN) && (issue_cnt < len_q) && credit_ok;
    assign rd_addr = rd_en ? (base_q + issue_cnt[ADDR_WIDTH-1:0]) : '0;

    // Zeroing happens on data return, never in the read cycle of that address.
    assign wr_en    = clear_q && ret_valid;
    assign wr_we    = clear_q && ret_valid;
    assign wr_addr  = (clear_q && ret_valid) ? ret_addr : '0;
    assign wr_wdata = '0;
    assign acc_mode = 1'b0;

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        assign lane_data[k*LANE_WIDTH +: LANE_WIDTH] =
            lane_mask(rd_data[k*LANE_WIDTH +: LANE_WIDTH], LOGQ);
    end

    drain_fifo #(
        .WIDTH (DATA_WIDTH + 1),
        .DEPTH (FIFO_DEPTH),
        .CW    (CW)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (ret_valid),
        .wdata ({ret_last, lane_data}),
        .pop   (fifo_pop),
        .rdata (fifo_head),
        .count (fifo_count)
    );

    assign m_valid  = (fifo_count != '0);
    assign fifo_pop = m_valid && m_ready;
    assign m_data   = m_valid ? fifo_head[DATA_WIDTH-1:0] : '0;
    assign m_last   = m_valid && fifo_head[DATA_WIDTH];

    assign busy      = (state == RUN) || (state == FLUSH);
    assign done      = (state == DONE);
    assign dbg_state = state;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            base_q    <= '0;
            len_q     <= '0;
            clear_q   <= 1'b0;
            issue_cnt <= '0;
            ret_cnt   <= '0;
            vld       <= '0;
            for (int i = 0; i < RD_LATENCY; i++) apipe[i] <= '0;
        end else begin
            vld[0]   <= rd_en;
            apipe[0] <= rd_addr;
            for (int i = 1; i < RD_LATENCY; i++) begin
                vld[i]   <= vld[i-1];
                apipe[i] <= apipe[i-1];
            end
            if (rd_en)     issue_cnt <= issue_cnt + 1'b1;
            if (ret_valid) ret_cnt   <= ret_cnt + 1'b1;

            case (state)
                IDLE: begin
                    if (start) begin
                        base_q    <= base_addr;
                        len_q     <= length;
                        clear_q   <= clear;
                        issue_cnt <= '0;
                        ret_cnt   <= '0;
                        state     <= (length == '0) ? DONE : RUN;
                    end
                end
                RUN: begin
                    if (rd_en && (issue_cnt + 1'b1 == len_q)) state <= FLUSH;
                end
                FLUSH: begin
                    // Finish as the last word leaves: nothing in flight and
                    // the FIFO is empty or emptying this cycle.
                    if ((vld == '0) &&
                        ((fifo_count == '0) || ((fifo_count == CW'(1)) && fifo_pop)))
                        state <= DONE;
                end
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_acc_drain.sv
module tb_acc_drain;

    localparam int AW   = 9;
    localparam int DW   = 64;
    localparam int FD   = 4;
    localparam int LOGQ = 15;
    localparam int MEMN = 1 << AW;

    logic          clk;
    logic          rst;
    logic          start;
    logic [AW-1:0] base_addr;
    logic [AW:0]   length;
    logic          clear;
    logic          busy, done, rd_en, wr_en, wr_we, acc_mode, m_valid, m_ready, m_last;
    logic [AW-1:0] rd_addr, wr_addr;
    logic [DW-1:0] rd_data, wr_wdata, m_data;
    logic [1:0]    dbg_state;

    acc_drain dut (
        .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .length(length),
        .clear(clear), .busy(busy), .done(done), .rd_en(rd_en), .rd_addr(rd_addr),
        .rd_data(rd_data), .wr_en(wr_en), .wr_we(wr_we), .wr_addr(wr_addr),
        .wr_wdata(wr_wdata), .acc_mode(acc_mode), .m_valid(m_valid), .m_ready(m_ready),
        .m_data(m_data), .m_last(m_last), .dbg_state(dbg_state)
    );

    // ---------------- clock / reset / cycle count ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- accumulator RAM model (2-cycle read) ----------------
    logic [DW-1:0] ram [MEMN];
    logic [DW-1:0] p1;
    logic          bd_en;
    logic [AW-1:0] bd_addr;
    logic [DW-1:0] bd_data;

    always @(posedge clk) begin
        if (rd_en) p1 <= ram[rd_addr];
        rd_data <= p1;
        if (wr_en && wr_we) ram[wr_addr] <= wr_wdata;
        if (bd_en) ram[bd_addr] <= bd_data;
    end

    // ---------------- reference model state ----------------
    logic [DW-1:0] ref_mem [MEMN];
    logic [DW:0]   exp_q[$];      // {last, data}
    logic [AW-1:0] exp_rd_q[$];
    logic [AW-1:0] exp_wr_q[$];

    int checks = 0;
    int failures = 0;

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    function automatic logic [DW-1:0] model_mask(input logic [DW-1:0] w);
        logic [DW-1:0] r;
        for (int k = 0; k < DW / 16; k++) begin
            r[k*16 +: 16] = 16'(int'(w[k*16 +: 16]) % (1 << LOGQ));
        end
        return r;
    endfunction

    // ---------------- monitor / scoreboard ----------------
    bit            mon_en = 1'b0;
    int            s_edge = 0;
    int            rel;
    int            first_rd_rel, first_valid_rel, done_rel;
    int            rd_cnt, wr_cnt, issued, xfers;
    logic [AW-1:0] rd_log[$];
    logic [DW-1:0] got_q[$];
    logic          got_last_q[$];
    logic          prev_stall;
    logic [DW-1:0] prev_data;
    logic          prev_last;
    logic [DW:0]   e;

    always @(negedge clk) begin
        if (mon_en) begin
            rel = cyc - s_edge + 1;
            if (rd_en) begin
                rd_cnt++;
                issued++;
                rd_log.push_back(rd_addr);
                if (first_rd_rel < 0) first_rd_rel = rel;
                if (exp_rd_q.size() == 0) chk("rd_extra", rd_en, 0);
                else chk("rd_addr", rd_addr, exp_rd_q.pop_front());
            end
            if (wr_en) begin
                wr_cnt++;
                if (exp_wr_q.size() == 0) chk("wr_extra", wr_en, 0);
                else chk("wr_addr", wr_addr, exp_wr_q.pop_front());
                chk("wr_we", wr_we, 1);
                chk("wr_wdata", wr_wdata, 0);
                chk("acc_mode", acc_mode, 0);
            end
            if (prev_stall) begin
                chk("stall_valid", m_valid, 1);
                chk("stall_data", m_data, prev_data);
                chk("stall_last", m_last, prev_last);
            end
            if (m_valid && first_valid_rel < 0) first_valid_rel = rel;
            if (m_valid && m_ready) begin
                xfers++;
                got_q.push_back(m_data);
                got_last_q.push_back(m_last);
                if (exp_q.size() == 0) chk("xfer_extra", m_valid, 0);
                else begin
                    e = exp_q.pop_front();
                    chk("m_data", m_data, e[DW-1:0]);
                    chk("m_last", m_last, e[DW]);
                end
            end
            chk("held_le_depth", (issued - xfers) > FD, 0);
            if (done) begin
                if (done_rel < 0) done_rel = rel;
                chk("done_pending", exp_q.size(), 0);
                chk("done_busy", busy, 0);
            end
            prev_stall = m_valid && !m_ready;
            prev_data  = m_data;
            prev_last  = m_last;
        end else begin
            prev_stall = 1'b0;
        end
    end

    // ---------------- ready driver ----------------
    int rdy_mode = 0;   // 0: always ready, 1: pattern 1,0,0,1, 2: random
    int rdy_idx = 0;
    initial begin
        m_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                1: begin
                    m_ready = (rdy_idx % 4 == 0) || (rdy_idx % 4 == 3);
                    rdy_idx++;
                end
                2: m_ready = ($urandom_range(0, 9) < 7);
                default: m_ready = 1'b1;
            endcase
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input int addr, input logic [DW-1:0] val);
        bd_en = 1'b1;
        bd_addr = AW'(addr);
        bd_data = val;
        ref_mem[addr] = val;
        tick();
        bd_en = 1'b0;
    endtask

    task automatic clear_log();
        first_rd_rel = -1;
        first_valid_rel = -1;
        done_rel = -1;
        rd_cnt = 0;
        wr_cnt = 0;
        issued = 0;
        xfers = 0;
        rd_log.delete();
        got_q.delete();
        got_last_q.delete();
    endtask

    task automatic launch(input int base, input int len, input bit clr);
        int a;
        clear_log();
        for (int i = 0; i < len; i++) begin
            a = (base + i) % MEMN;
            exp_rd_q.push_back(AW'(a));
            exp_q.push_back({(i == len - 1), model_mask(ref_mem[a])});
            if (clr) begin
                exp_wr_q.push_back(AW'(a));
                ref_mem[a] = '0;
            end
        end
        base_addr = AW'(base);
        length = (AW + 1)'(len);
        clear = clr;
        start = 1'b1;
        tick();
        s_edge = cyc;
        start = 1'b0;
        base_addr = AW'($urandom);
        length = (AW + 1)'($urandom_range(0, MEMN));
        clear = ~clr;
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        while (done_rel < 0 && n < budget) begin
            tick();
            n++;
        end
        chk("done_seen", done_rel >= 0, 1);
        tick();
        chk("rd_left", exp_rd_q.size(), 0);
        chk("wr_left", exp_wr_q.size(), 0);
        chk("xfer_left", exp_q.size(), 0);
    endtask

    task automatic run_drain(input int base, input int len, input bit clr);
        launch(base, len, clr);
        wait_done(2000);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_rd_en"}, rd_en, 0);
        chk({tag, "_rd_addr"}, rd_addr, 0);
        chk({tag, "_wr_en"}, wr_en, 0);
        chk({tag, "_wr_we"}, wr_we, 0);
        chk({tag, "_wr_addr"}, wr_addr, 0);
        chk({tag, "_wr_wdata"}, wr_wdata, 0);
        chk({tag, "_acc_mode"}, acc_mode, 0);
        chk({tag, "_m_valid"}, m_valid, 0);
        chk({tag, "_m_data"}, m_data, 0);
        chk({tag, "_m_last"}, m_last, 0);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        rst = 1'b1;
        start = 1'b0;
        base_addr = '0;
        length = '0;
        clear = 1'b0;
        bd_en = 1'b0;
        bd_addr = '0;
        bd_data = '0;
        clear_log();
        for (int a = 0; a < MEMN; a++) preload(a, {$urandom, $urandom});
        check_all_zero("reset");
        rst = 1'b0;
        tick();
        mon_en = 1'b1;

        // Directed: masked readout and cycle timing
        for (int i = 0; i < 4; i++) preload(16 + i, 64'h0001_0002_0003_8004 + 64'(i));
        run_drain(16, 4, 1'b0);
        chk("t1_count", got_q.size(), 4);
        for (int i = 0; i < 4 && i < got_q.size(); i++) begin
            chk("t1_word", got_q[i], 64'h0001_0002_0003_0004 + 64'(i));
            chk("t1_last", got_last_q[i], (i == 3));
        end
        chk("t1_first_rd", first_rd_rel, 1);
        chk("t1_first_valid", first_valid_rel, 4);
        chk("t1_done", done_rel, 8);

        // Directed: clear, then re-read a zeroed address
        run_drain(16, 4, 1'b1);
        chk("t2_writes", wr_cnt, 4);
        run_drain(16, 1, 1'b0);
        chk("t2_count", got_q.size(), 1);
        if (got_q.size() > 0) chk("t2_zeroed", got_q[0], 0);

        // Directed: wrap at the top of memory
        run_drain(510, 4, 1'b0);
        chk("t3_reads", rd_log.size(), 4);
        if (rd_log.size() == 4) begin
            chk("t3_a0", rd_log[0], 9'h1FE);
            chk("t3_a1", rd_log[1], 9'h1FF);
            chk("t3_a2", rd_log[2], 9'h000);
            chk("t3_a3", rd_log[3], 9'h001);
        end

        // Directed: backpressure pattern 1,0,0,1
        rdy_idx = 0;
        rdy_mode = 1;
        run_drain(64, 8, 1'b0);
        chk("t4_count", got_q.size(), 8);
        rdy_mode = 0;

        // Directed: zero length
        run_drain(85, 0, 1'b1);
        chk("t5_rd", rd_cnt, 0);
        chk("t5_wr", wr_cnt, 0);
        chk("t5_done", done_rel, 1);

        // Directed: reset mid-drain with clear
        launch(128, 16, 1'b1);
        for (int i = 0; i < 7; i++) tick();
        rst = 1'b1;
        mon_en = 1'b0;
        tick();
        check_all_zero("midrst");
        rst = 1'b0;
        exp_q.delete();
        exp_rd_q.delete();
        exp_wr_q.delete();
        clear_log();
        mon_en = 1'b1;
        for (int i = 0; i < 16; i++) preload(128 + i, {$urandom, $urandom});
        for (int i = 0; i < 6; i++) tick();
        chk("t6_no_wr", wr_cnt, 0);
        chk("t6_no_rd", rd_cnt, 0);
        run_drain(128, 16, 1'b1);
        chk("t6_count", got_q.size(), 16);
        chk("t6_writes", wr_cnt, 16);

        // Randomised drains against the model
        for (int t = 0; t < 16; t++) begin
            rdy_mode = (t % 3 == 0) ? 0 : 2;
            run_drain($urandom_range(0, MEMN - 1), $urandom_range(1, 40), 1'($urandom_range(0, 1)));
        end
        rdy_mode = 0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
